// File: rtl/mem_stage_hs.sv
// rtl/mem_stage_hs.sv - MEM pipeline stage with req/ack data-memory handshake and timeout watchdog
module mem_stage_hs #(
  parameter int DATA_W  = 16,
  parameter int ADDR_W  = 8,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_cpu_state,
  input  logic [DATA_W-1:0] i_mem_inst,
  input  logic [DATA_W-1:0] i_alu_result,
  input  logic [DATA_W-1:0] i_store_data,
  input  logic              i_nf,
  input  logic              i_zf,
  input  logic [DATA_W-1:0] i_mem_rdata,
  input  logic              i_mem_ack,
  output logic [DATA_W-1:0] o_wb_inst,
  output logic [DATA_W-1:0] o_wb_data,
  output logic              o_mem_req,
  output logic              o_mem_we,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [DATA_W-1:0] o_mem_wdata,
  output logic              o_stall,
  output logic              o_is_branch,
  output logic              o_mem_err
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  localparam logic [3:0] OP_BN    = 4'b1001;
  localparam logic [3:0] OP_BZ    = 4'b1011;
  localparam logic [3:0] OP_LOAD  = 4'b1101;
  localparam logic [3:0] OP_STORE = 4'b1110;

  typedef enum logic {IDLE, WAIT} state_t;

  state_t              r_state;
  logic [CNT_W-1:0]    r_cnt;
  logic [DATA_W-1:0]   r_wb_inst;
  logic [DATA_W-1:0]   r_wb_data;
  logic                r_mem_req;
  logic                r_mem_we;
  logic [ADDR_W-1:0]   r_mem_addr;
  logic [DATA_W-1:0]   r_mem_wdata;
  logic                r_mem_err;

  logic [3:0]          w_op;
  logic                w_is_mem;
  logic                w_timeout_hit;

  assign w_op          = i_mem_inst[DATA_W-1 -: 4];
  assign w_is_mem      = (w_op == OP_LOAD) || (w_op == OP_STORE);
  // Last permitted WAIT cycle: without an ack on this edge the access is abandoned.
  assign w_timeout_hit = (r_state == WAIT) && (r_cnt == CNT_W'(TIMEOUT - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_wb_inst   <= '0;
      r_wb_data   <= '0;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_mem_err   <= 1'b0;
    end else if (i_cpu_state) begin
      case (r_state)
        IDLE: begin
          if (w_is_mem) begin
            r_mem_req   <= 1'b1;
            r_mem_we    <= (w_op == OP_STORE);
            r_mem_addr  <= i_alu_result[ADDR_W-1:0];
            r_mem_wdata <= i_store_data;
            r_wb_inst   <= '0;
            r_cnt       <= '0;
            r_state     <= WAIT;
          end else begin
            r_wb_inst <= i_mem_inst;
            r_wb_data <= i_alu_result;
          end
        end
        WAIT: begin
          if (i_mem_ack) begin
            r_wb_inst <= i_mem_inst;
            r_wb_data <= (w_op == OP_LOAD) ? i_mem_rdata : i_alu_result;
            r_mem_req <= 1'b0;
            r_state   <= IDLE;
          end else if (w_timeout_hit) begin
            r_mem_req <= 1'b0;
            r_mem_err <= 1'b1;
            r_wb_inst <= '0;
            r_state   <= IDLE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign o_stall     = ((r_state == IDLE) && w_is_mem) ||
                       ((r_state == WAIT) && !i_mem_ack && !w_timeout_hit);
  assign o_is_branch = (r_state == IDLE) &&
                       (((w_op == OP_BN) && i_nf) || ((w_op == OP_BZ) && i_zf));

  assign o_wb_inst   = r_wb_inst;
  assign o_wb_data   = r_wb_data;
  assign o_mem_req   = r_mem_req;
  assign o_mem_we    = r_mem_we;
  assign o_mem_addr  = r_mem_addr;
  assign o_mem_wdata = r_mem_wdata;
  assign o_mem_err   = r_mem_err;

endmodule

// File: tb/tb_mem_stage_hs.sv
// tb/tb_mem_stage_hs.sv - random-stimulus bench for mem_stage_hs against a transaction-level model
module tb_mem_stage_hs;
  localparam int DW = 16;
  localparam int AW = 8;
  localparam int TO = 15;

  logic          clk = 1'b0;
  logic          reset;
  logic          cpu_state;
  logic [DW-1:0] mem_inst, alu_result, store_data, mem_rdata;
  logic          nf, zf, mem_ack;
  logic [DW-1:0] wb_inst, wb_data, mem_wdata;
  logic          mem_req, mem_we, stall, is_branch, mem_err;
  logic [AW-1:0] mem_addr;

  always #5 clk = ~clk;

  mem_stage_hs #(.DATA_W(DW), .ADDR_W(AW), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .i_cpu_state(cpu_state), .i_mem_inst(mem_inst),
    .i_alu_result(alu_result), .i_store_data(store_data), .i_nf(nf), .i_zf(zf),
    .i_mem_rdata(mem_rdata), .i_mem_ack(mem_ack), .o_wb_inst(wb_inst), .o_wb_data(wb_data),
    .o_mem_req(mem_req), .o_mem_we(mem_we), .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata),
    .o_stall(stall), .o_is_branch(is_branch), .o_mem_err(mem_err)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: one outstanding access, tracked by how many WAIT cycles it has used.
  bit            m_busy;
  int            m_waited;
  logic [DW-1:0] m_wb_inst, m_wb_data, m_wdata;
  logic [AW-1:0] m_addr;
  logic          m_req, m_we, m_err;

  function automatic logic [3:0] op_of(input logic [DW-1:0] inst);
    return inst[DW-1 -: 4];
  endfunction

  function automatic bit is_mem_op(input logic [DW-1:0] inst);
    return op_of(inst) == 4'hD || op_of(inst) == 4'hE;
  endfunction

  task automatic model_reset();
    m_busy = 0; m_waited = 0; m_wb_inst = '0; m_wb_data = '0; m_wdata = '0;
    m_addr = '0; m_req = 0; m_we = 0; m_err = 0;
  endtask

  function automatic bit model_stall();
    if (!m_busy) return is_mem_op(mem_inst);
    return !mem_ack && (m_waited + 1 < TO);
  endfunction

  function automatic bit model_branch();
    if (m_busy) return 0;
    return (op_of(mem_inst) == 4'h9 && nf) || (op_of(mem_inst) == 4'hB && zf);
  endfunction

  task automatic model_step();
    if (!cpu_state) return;
    if (!m_busy) begin
      if (is_mem_op(mem_inst)) begin
        m_req = 1; m_we = (op_of(mem_inst) == 4'hE); m_addr = alu_result[AW-1:0];
        m_wdata = store_data; m_wb_inst = '0; m_busy = 1; m_waited = 0;
      end else begin
        m_wb_inst = mem_inst; m_wb_data = alu_result;
      end
    end else if (mem_ack) begin
      m_wb_inst = mem_inst;
      m_wb_data = (op_of(mem_inst) == 4'hD) ? mem_rdata : alu_result;
      m_req = 0; m_busy = 0;
    end else if (m_waited + 1 == TO) begin
      m_req = 0; m_err = 1; m_wb_inst = '0; m_busy = 0;
    end else begin
      m_waited++;
    end
  endtask

  task automatic check_regs(input string where);
    check({where, ".wb_inst"},   32'(wb_inst),   32'(m_wb_inst));
    check({where, ".wb_data"},   32'(wb_data),   32'(m_wb_data));
    check({where, ".mem_req"},   32'(mem_req),   32'(m_req));
    check({where, ".mem_we"},    32'(mem_we),    32'(m_we));
    check({where, ".mem_addr"},  32'(mem_addr),  32'(m_addr));
    check({where, ".mem_wdata"}, 32'(mem_wdata), 32'(m_wdata));
    check({where, ".mem_err"},   32'(mem_err),   32'(m_err));
  endtask

  task automatic check_comb(input string where);
    check({where, ".stall"},     32'(stall),     32'(model_stall()));
    check({where, ".is_branch"}, 32'(is_branch), 32'(model_branch()));
  endtask

  task automatic clock_edge(input string where);
    model_step();
    @(posedge clk);
    #1;
    check_regs(where);
  endtask

  function automatic logic [DW-1:0] rand_inst();
    logic [3:0] ops [8] = '{4'h0, 4'h1, 4'h2, 4'h7, 4'h9, 4'hB, 4'hD, 4'hE};
    return {ops[$urandom_range(0, 7)], 12'($urandom)};
  endfunction

  int  age, delay, timeouts, retires;
  bit  advance;

  initial begin
    reset = 1; cpu_state = 0; mem_inst = '0; alu_result = '0; store_data = '0;
    nf = 0; zf = 0; mem_rdata = '0; mem_ack = 0;
    model_reset();
    @(posedge clk); #1;
    check_regs("reset");
    check("reset.stall", 32'(stall), 32'(0));
    reset = 0;

    // Simple ALU op retires after one edge.
    cpu_state = 1; mem_inst = 16'h2123; alu_result = 16'h0042;
    #1; check_comb("add");
    clock_edge("add");
    check("add.wb_data_const", 32'(wb_data), 32'h0042);
    check("add.wb_inst_const", 32'(wb_inst), 32'h2123);

    // Branch resolution in IDLE.
    mem_inst = 16'hB000; zf = 1; nf = 0; #1;
    check("bz_taken", 32'(is_branch), 32'(1));
    mem_inst = 16'h9000; zf = 0; nf = 0; #1;
    check("bn_not_taken", 32'(is_branch), 32'(0));
    clock_edge("bn");

    age = 0; delay = 0; advance = 1; timeouts = 0; retires = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if ($urandom_range(0, 299) == 0) begin
        reset = 1; #1;
        model_reset();
        check_regs("async_reset");
        @(posedge clk); #1;
        reset = 0; mem_ack = 0; age = 0; advance = 1;
        continue;
      end
      if (advance) begin
        mem_inst = rand_inst(); alu_result = 16'($urandom); store_data = 16'($urandom);
        nf = 1'($urandom); zf = 1'($urandom);
      end
      cpu_state = ($urandom_range(0, 9) != 0);
      if (mem_req) begin
        if (age >= delay) begin
          if (!mem_ack) mem_rdata = 16'($urandom);
          mem_ack = 1;
        end
        age++;
      end else begin
        mem_ack = 0; age = 0;
        delay = ($urandom_range(0, 9) < 7) ? $urandom_range(0, 4) : $urandom_range(10, 25);
      end
      #1;
      check_comb("rnd");
      advance = cpu_state && !model_stall();
      if (m_busy && cpu_state && mem_ack) retires++;
      if (m_busy && cpu_state && !mem_ack && m_waited + 1 == TO) timeouts++;
      clock_edge("rnd");
    end
    check("saw_timeout", 32'(timeouts > 0), 32'(1));
    check("saw_retire", 32'(retires > 0), 32'(1));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
